ysyx_25030077_imm_stage: RTL
============================

# ysyx_25030077_imm_stage

Registered, parametrised immediate-generation stage for the ysyx_25030077 core, placed between instruction fetch and the execute/ALU operand mux. It extracts and sign- or zero-extends the immediate for every RV32I/RV64I format plus CSR zimm, at width XLEN. The PC tag travels alongside the immediate. A valid/ready handshake with a 2-entry skid buffer gives full throughput, and `in_ready` is driven directly from a flop.

## Interface
- XLEN, default 32: datapath width; legal values 32 or 64.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous; discards every held entry.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept; registered, equals "skid entry empty".
- in_inst  input  32  raw instruction word.
- in_type  input  4  immediate type code (see Operation).
- in_pc  input  XLEN  PC tag, passed through unchanged.
- out_valid  output  1  output entry holds data.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate.
- out_pc  output  XLEN  PC tag of the output entry.
- out_err  output  1  in_type was an undefined code; out_imm is 0 in that case.

## Operation
- Type codes, with i = in_inst and S() meaning sign-extend to XLEN:
  - 0: none, result 0.
  - 1: I, S(i[31:20]).
  - 2: U, S({i[31:12],12'h0}); sign-extends from bit 31 when XLEN=64.
  - 3: constant 4.
  - 4: S, S({i[31:25],i[11:7]}).
  - 5: shamt, zero-extended i[24:20] when XLEN=32, i[25:20] when XLEN=64.
  - 6: zero-extended i[31:20].
  - 7: B, S({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - 8: J, S({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - 9: CSR zimm, zero-extended i[19:15].
  - 10–15: out_imm 0, out_err 1.
- The immediate is computed combinationally from the input. It is stored together with pc and err in the entry that accepts it.
- Two entries: MAIN drives the outputs; SKID catches one beat when MAIN is full and stalled.
- States:
  - EMPTY: no entry valid.
  - ONE: MAIN valid.
  - TWO: MAIN and SKID valid.
- Handshakes: a transfer in occurs when in_valid and in_ready are both high; a transfer out occurs when out_valid and out_ready are both high.
- Transitions:
  - EMPTY, transfer in → ONE (load MAIN).
  - ONE, transfer in with no transfer out → TWO (load SKID).
  - ONE, transfer in and transfer out → ONE (MAIN reloaded with the new beat).
  - ONE, transfer out only → EMPTY.
  - TWO, transfer out → ONE (SKID moves to MAIN). in_ready is low in TWO, so no input is accepted there.
- Order is strictly FIFO. No beat is dropped or duplicated.
- flush takes priority over every transfer in the same cycle. Next state is EMPTY; input presented that cycle is discarded.

## Timing
- Latency: 1 cycle from the input transfer to out_valid, when the stage was EMPTY or a transfer out coincides with the input transfer.
- Throughput: 1 beat/cycle while out_ready stays high.
- in_ready is a flop output with no combinational path from out_ready. It goes low the cycle after entry to TWO and returns high the cycle after leaving TWO.
- out_imm, out_pc and out_err are flop outputs. They hold stable while out_valid is high and out_ready is low.
- Reset values:
  - out_valid 0, in_ready 1.
  - out_imm 0, out_pc 0, out_err 0.
  - State EMPTY; SKID contents 0.
- Reset asserted mid-transfer: state is lost at once and outputs go to their reset values asynchronously. The first transfer is accepted at the first clock edge after reset deasserts.
- After flush: out_valid is 0 and in_ready is 1 in the following cycle.

## Test plan
- XLEN=32, basic formats, out_ready=1:
  - type1 inst 0xFFF00093 → out_imm 0xFFFFFFFF one cycle later.
  - type4 inst 0xFE20AE23 → 0xFFFFFFFC.
  - type7 inst 0xFE000EE3 → 0xFFFFFFFC.
  - type8 inst 0x001000EF → 0x00000800.
- XLEN=64, extension and shamt:
  - type2 inst 0x80000037 → 0xFFFFFFFF80000000.
  - type5 inst with i[25:20]=0x3F → 0x000000000000003F.
  - type11 → out_imm 0, out_err 1.
- Backpressure: out_ready=0, send pc 0x100 then 0x104.
  - in_ready drops the cycle after the second accept; a third beat held on in_valid is not accepted.
  - Raise out_ready: outputs 0x100, 0x104, then the third beat, in order; in_ready returns to 1.
- Streaming: 100 back-to-back beats with out_ready=1 → 100 outputs on consecutive cycles, in_ready never low.
- Flush while in TWO, with in_valid high the same cycle → next cycle out_valid=0 and in_ready=1; the flushed beats and the coincident beat never appear.
- Async reset pulsed between clock edges while in ONE → out_valid and out_imm go to 0 before the next edge; a normal transfer completes after release.

Source files
------------

// File: rtl/ysyx_25030077_imm_stage.sv
// Immediate-generation stage: decodes the instruction immediate at XLEN and
// queues it with its PC in a two-entry skid buffer behind a valid/ready pair.
module ysyx_25030077_imm_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [3:0]      in_type,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_err
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            in_ready_q, out_valid_q;
    logic [XLEN-1:0] main_imm_q, main_pc_q;
    logic [XLEN-1:0] skid_imm_q, skid_pc_q;
    logic            main_err_q, skid_err_q;
    logic [XLEN-1:0] imm_d;
    logic            err_d;
    logic            xfer_in, xfer_out;
    logic            load_main, load_skid, pop_skid;
    logic            unused_opcode;

    assign unused_opcode = ^in_inst[6:0];

    // Signed casts sign-extend the raw field to XLEN; unsigned ones zero-extend.
    always_comb begin
        imm_d = '0;
        err_d = 1'b0;
        unique case (in_type)
            4'd0: imm_d = '0;
            4'd1: imm_d = XLEN'($signed(in_inst[31:20]));
            4'd2: imm_d = XLEN'($signed({in_inst[31:12], 12'h000}));
            4'd3: imm_d = XLEN'(4);
            4'd4: imm_d = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            4'd5: imm_d = (XLEN == 64) ? XLEN'(in_inst[25:20])
                                       : XLEN'(in_inst[24:20]);
            4'd6: imm_d = XLEN'(in_inst[31:20]);
            4'd7: imm_d = XLEN'($signed({in_inst[31], in_inst[7],
                                         in_inst[30:25], in_inst[11:8],
                                         1'b0}));
            4'd8: imm_d = XLEN'($signed({in_inst[31], in_inst[19:12],
                                         in_inst[20], in_inst[30:21],
                                         1'b0}));
            4'd9: imm_d = XLEN'(in_inst[19:15]);
            default: begin
                imm_d = '0;
                err_d = 1'b1;
            end
        endcase
    end

    assign xfer_in  = in_valid & in_ready_q;
    assign xfer_out = out_valid_q & out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (xfer_in) begin
                        load_main = 1'b1;
                        state_d   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (xfer_in && !xfer_out) begin
                        load_skid = 1'b1;
                        state_d   = S_TWO;
                    end else if (xfer_in) begin
                        load_main = 1'b1;
                    end else if (xfer_out) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (xfer_out) begin
                        pop_skid = 1'b1;
                        state_d  = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_imm_q  <= '0;
            main_pc_q   <= '0;
            main_err_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_pc_q   <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != S_TWO);
            out_valid_q <= (state_d != S_EMPTY);
            if (load_main) begin
                main_imm_q <= imm_d;
                main_pc_q  <= in_pc;
                main_err_q <= err_d;
            end else if (pop_skid) begin
                main_imm_q <= skid_imm_q;
                main_pc_q  <= skid_pc_q;
                main_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_imm_q <= imm_d;
                skid_pc_q  <= in_pc;
                skid_err_q <= err_d;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = main_imm_q;
    assign out_pc    = main_pc_q;
    assign out_err   = main_err_q;

endmodule
